boot_load_ctrl: RTL

- Sequences the UART program loader and owns the instruction-memory write port.
- On a load request it holds the CPU in reset, enables the loader, and turns each completed loader word into a single-cycle imem write.
- Loading ends after a quiet period on the loader. The controller then keeps the CPU in reset for a short hold and releases it to run the new image.
- Sits between the loader, the imem write port and the CPU reset input.

---
 rtl/boot_load_ctrl_pkg.sv | 9 +
 rtl/boot_load_ctrl_sync_edge.sv | 24 ++
 rtl/boot_load_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/boot_load_ctrl_pkg.sv
// boot_pkg: shared state encoding and default timing for the boot loader controller
package boot_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_e;
  localparam logic [31:0] ADDR_ALL_ONES = 32'hFFFF_FFFF;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_MAX_WORDS = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 2_000_000;
  localparam int DEF_HOLD_CYCLES = 16;
endpackage

// File: rtl/boot_load_ctrl_sync_edge.sv
// sync_edge: 2-flop synchroniser with a registered rising-edge pulse, 3 clk from pin to pulse
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic s1_q, s2_q, s3_q, pulse_q, pulse_d;
  always_comb pulse_d = s2_q & ~s3_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
      pulse_q <= pulse_d;
    end
  end
  assign pulse = pulse_q;
endmodule

// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: sequences the UART loader, drives the imem write port and holds the CPU in reset while loading
module boot_load_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  output logic              ld_enable,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       word_count
);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  logic req_pulse;
  sync_edge u_sync (.clk(clk), .rst(rst), .din(load_req), .pulse(req_pulse));
  state_e state_q, state_d;
  logic ld_wr_q, ld_wr_d, we_q, we_d, ovf_q, ovf_d, done_q, done_d, en_q, en_d, cpu_q, cpu_d;
  logic [TO_W-1:0] idle_q, idle_d, idle_inc;
  logic [HC_W-1:0] hold_q, hold_d;
  logic [15:0] wc_q, wc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic wr_edge, artefact, in_range, timeout;
  assign wr_edge = (state_q == LOAD) && ld_wr && !ld_wr_q;
  assign artefact = ld_addr == ADDR_W'(ADDR_ALL_ONES);
  assign in_range = ld_addr < ADDR_W'(MAX_WORDS);
  assign timeout = idle_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign idle_inc = (idle_q == TO_W'(TIMEOUT_CYCLES)) ? idle_q : idle_q + TO_W'(1);
  always_comb begin
    state_d = state_q;
    idle_d = idle_q;
    hold_d = hold_q;
    wc_d = wc_q;
    ovf_d = ovf_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    done_d = 1'b0;
    // a high ld_wr when the loader is first enabled must not look like an edge
    ld_wr_d = (state_q == LOAD) ? ld_wr : 1'b1;
    case (state_q)
      RUN: if (req_pulse) begin
        state_d = LOAD;
        wc_d = '0;
        ovf_d = 1'b0;
        idle_d = '0;
      end
      LOAD: if (req_pulse) state_d = RUN;
      else if (wr_edge && !artefact) begin
        idle_d = '0;
        if (in_range) begin
          we_d = 1'b1;
          addr_d = ld_addr;
          wdata_d = ld_data;
          wc_d = (&wc_q) ? wc_q : wc_q + 16'd1;
        end else ovf_d = 1'b1;
      end else begin
        idle_d = idle_inc;
        if (timeout && wc_q != '0) begin
          state_d = HOLD;
          hold_d = '0;
        end
      end
      HOLD: if (hold_q == HC_W'(HOLD_CYCLES - 1)) begin
        state_d = RUN;
        done_d = 1'b1;
      end else hold_d = hold_q + HC_W'(1);
      default: state_d = RUN;
    endcase
    en_d = state_d == LOAD;
    cpu_d = state_d != RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ld_wr_q <= 1'b0;
      idle_q <= '0;
      hold_q <= '0;
      wc_q <= '0;
      ovf_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
      en_q <= 1'b0;
      cpu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_wr_q <= ld_wr_d;
      idle_q <= idle_d;
      hold_q <= hold_d;
      wc_q <= wc_d;
      ovf_q <= ovf_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
      en_q <= en_d;
      cpu_q <= cpu_d;
    end
  end
  assign ld_enable = en_q;
  assign cpu_rst = cpu_q;
  assign busy = cpu_q;
  assign done = done_q;
  assign overflow = ovf_q;
  assign word_count = wc_q;
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
endmodule
